ctrl_escritura_banco: RTL and testbench
=======================================

# ctrl_escritura_banco

Write-port controller and scoreboard for `banco_registros`. It shares the register file's single write port between two requesters: requester 0 is ALU writeback and requester 1 is the load unit. Arbitration is round-robin with a valid/ready handshake, and each granted write is driven to the port one cycle later. It also tracks pending destination registers reserved by decode, so decode can stall on read-after-write hazards.

## Interface
Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register index width (32 registers)

Ports:
- CLK  in  1  system clock, all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- req0_valid  in  1  ALU writeback request
- req0_reg  in  ADDR_W  ALU destination register
- req0_data  in  DATA_W  ALU result
- req0_ready  out  1  request 0 accepted this cycle
- req1_valid  in  1  load-unit writeback request
- req1_reg  in  ADDR_W  load destination register
- req1_data  in  DATA_W  load data
- req1_ready  out  1  request 1 accepted this cycle
- rsv_valid  in  1  decode reserves a destination register
- rsv_reg  in  ADDR_W  register to reserve
- rs1, rs2  in  ADDR_W  source registers of the instruction in decode
- stall  out  1  hazard on rs1 or rs2
- writeReg  out  ADDR_W  to `banco_registros.writeReg`
- writeData  out  DATA_W  to `banco_registros.writeData`
- RegWrite  out  1  to `banco_registros.RegWrite`
- pending  out  32  scoreboard vector, bit i means register i has a write outstanding

## Operation
- **Arbitration** (combinational grant):
  - If only one requester is valid, it is granted.
  - If both are valid, the requester that was not granted last wins.
  - `last_grant` updates only on an accepted request whose register is non-zero.
- **Ready:** `reqN_ready = grant_N`. A transfer completes when valid and ready are both high. At most one request is accepted per cycle, and the write stage never backpressures.
- **Output stage:**
  - On acceptance with reg != 0, the next edge loads `writeReg`/`writeData` and sets `RegWrite=1`.
  - With no acceptance, the next edge clears `RegWrite`. `writeReg`/`writeData` hold their last values.
- **x0 writes:** accepted (ready=1) but discarded. `RegWrite` stays 0, `last_grant` is unchanged, and the scoreboard is unaffected.
- **Scoreboard set:** `rsv_valid` with `rsv_reg != 0` sets `pending[rsv_reg]` at the next edge. Reserving x0 is ignored, so `pending[0]` is constantly 0.
- **Scoreboard clear:** acceptance of a write to reg r clears `pending[r]` at the next edge.
- **Simultaneous events:**
  - A reserve and a clear of the same register in one cycle: the reserve wins, and the bit ends up set.
  - A reserve and a clear of different registers in one cycle: both take effect.
- **Stall** (combinational) is asserted for rs1 (and likewise for rs2) if either holds:
  - `pending[rs1]` is set.
  - `RegWrite && writeReg==rs1 && rs1!=0`, which covers the write landing this cycle.
- **No bypass:** data is never forwarded through this block.

## Timing
- **Reset values:** RegWrite=0, writeReg=0, writeData=0, pending=0, `last_grant`=1 (requester 0 has priority first). With no valid requests after reset, stall=0 and both readies are 0.
- **Reset mid-operation:** RST wins over every same-cycle event. The accepted write in that cycle is dropped and the scoreboard is cleared.
- **Latency:**
  - Request accepted in cycle n gives RegWrite=1 in cycle n+1. The register file captures it at the end of cycle n+1, so the value is readable from cycle n+2.
  - `pending` set or clear is visible in the cycle after the event.
- **Throughput:** one write per cycle sustained. With both requesters continuously valid, grants alternate 0,1,0,1.
- **Handshake rule:** a requester must hold valid, reg and data stable until it sees ready.

## Test plan
- **Reset:** hold RST for 2 cycles with both reqs valid. Expect RegWrite=0, pending=0, both ready=0 during reset. In the first cycle after release, req0_ready=1.
- **Single request:** req1_valid, reg=13, data=32'h0000A234. Expect req1_ready=1 in the same cycle, then writeReg=13, writeData=32'h0000A234, RegWrite=1 in the next cycle. A subsequent read of register 13 in `banco_registros` returns 32'h0000A234.
- **Contention:** both valid for 4 cycles with distinct regs 3 and 5. Expect grant order 0,1,0,1, with each held request accepted once its turn comes.
- **x0:** req0 reg=0, data=32'h000000A1. Expect ready=1 and RegWrite remaining 0. Register 0 still reads 0, and the next contention is still granted to requester 0.
- **Scoreboard:**
  - Reserve reg 7, then set rs1=7. Expect stall=1 from the next cycle.
  - Then req1 writes reg 7. Expect stall=1 during the RegWrite cycle and stall=0 in the cycle after.
  - Reserve and clear of reg 7 in the same cycle leaves pending[7]=1.
- **Reset mid-write:** assert RST in the same cycle req0 is accepted for reg 9 with pending[9]=1. Expect RegWrite=0 next cycle and pending=0.

Source files
------------

// File: rtl/ctrl_escritura_banco_if.sv
// Bundle of the write-port requests, decode reservation/hazard signals and
// the register-file write port driven by ctrl_escritura_banco.
interface ctrl_escritura_banco_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    localparam int NREG = 1 << ADDR_W;

    logic              req0_valid;
    logic [ADDR_W-1:0] req0_reg;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;

    logic              req1_valid;
    logic [ADDR_W-1:0] req1_reg;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;

    logic              rsv_valid;
    logic [ADDR_W-1:0] rsv_reg;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic              stall;

    logic [ADDR_W-1:0] writeReg;
    logic [DATA_W-1:0] writeData;
    logic              RegWrite;
    logic [NREG-1:0]   pending;

    // Requesters, decode and the register file side.
    modport master (
        output req0_valid, req0_reg, req0_data,
        input  req0_ready,
        output req1_valid, req1_reg, req1_data,
        input  req1_ready,
        output rsv_valid, rsv_reg, rs1, rs2,
        input  stall,
        input  writeReg, writeData, RegWrite, pending
    );

    // The controller itself.
    modport slave (
        input  req0_valid, req0_reg, req0_data,
        output req0_ready,
        input  req1_valid, req1_reg, req1_data,
        output req1_ready,
        input  rsv_valid, rsv_reg, rs1, rs2,
        output stall,
        output writeReg, writeData, RegWrite, pending
    );
endinterface

// File: rtl/ctrl_escritura_banco.sv
// Round-robin arbiter for the single register-file write port (ALU vs load
// unit), registered write stage, and a pending-destination scoreboard for decode.
module ctrl_escritura_banco #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                  CLK,
    input  logic                  RST,
    ctrl_escritura_banco_if.slave bus
);
    localparam int NREG = 1 << ADDR_W;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_t;

    req_id_t           r_last_grant;
    req_id_t           w_last_grant_next;
    logic              r_reg_write;
    logic [ADDR_W-1:0] r_write_reg;
    logic [DATA_W-1:0] r_write_data;
    logic [NREG-1:0]   r_pending;
    logic [NREG-1:0]   w_pending_next;

    logic              w_grant0;
    logic              w_grant1;
    logic              w_accept;
    req_id_t           w_acc_id;
    logic [ADDR_W-1:0] w_acc_reg;
    logic [DATA_W-1:0] w_acc_data;
    logic              w_acc_live;
    logic              w_rsv_live;
    logic              w_haz_rs1;
    logic              w_haz_rs2;

    // Grant: a lone requester wins; on contention the one not granted last wins.
    // Reset holds both readies low so nothing is accepted while RST is high.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path leaves it unassigned and no latch is inferred.
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (!RST) begin
            if (bus.req0_valid && bus.req1_valid) begin
                if (r_last_grant == REQ1) begin
                    w_grant0 = 1'b1;
                end else begin
                    w_grant1 = 1'b1;
                end
            end else begin
                w_grant0 = bus.req0_valid;
                w_grant1 = bus.req1_valid;
            end
        end
    end

    assign w_accept   = w_grant0 || w_grant1;
    assign w_acc_id   = w_grant1 ? REQ1 : REQ0;
    assign w_acc_reg  = w_grant1 ? bus.req1_reg  : bus.req0_reg;
    assign w_acc_data = w_grant1 ? bus.req1_data : bus.req0_data;
    // x0 writes complete the handshake but leave no trace anywhere.
    assign w_acc_live = w_accept && (w_acc_reg != '0);
    assign w_rsv_live = bus.rsv_valid && (bus.rsv_reg != '0);

    always_comb begin
        w_last_grant_next = r_last_grant;
        if (w_acc_live) begin
            w_last_grant_next = w_acc_id;
        end
    end

    // Clear first, then set: a same-register reserve overrides the clear.
    always_comb begin
        w_pending_next = r_pending;
        if (w_acc_live) begin
            w_pending_next[w_acc_reg] = 1'b0;
        end
        if (w_rsv_live) begin
            w_pending_next[bus.rsv_reg] = 1'b1;
        end
        w_pending_next[0] = 1'b0;
    end

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (RST) begin
            r_last_grant <= REQ1;
            r_reg_write  <= 1'b0;
            r_write_reg  <= '0;
            r_write_data <= '0;
            // NOTE: the scoreboard must start empty, so this flop vector is
            // reset like any control register rather than left unknown.
            r_pending    <= '0;
        end else begin
            r_last_grant <= w_last_grant_next;
            r_reg_write  <= w_acc_live;
            r_pending    <= w_pending_next;
            if (w_acc_live) begin
                r_write_reg  <= w_acc_reg;
                r_write_data <= w_acc_data;
            end
        end
    end

    // A source is hazardous while reserved or while its write is landing now.
    assign w_haz_rs1 = (bus.rs1 != '0) &&
                       (r_pending[bus.rs1] || (r_reg_write && (r_write_reg == bus.rs1)));
    assign w_haz_rs2 = (bus.rs2 != '0) &&
                       (r_pending[bus.rs2] || (r_reg_write && (r_write_reg == bus.rs2)));

    assign bus.req0_ready = w_grant0;
    assign bus.req1_ready = w_grant1;
    assign bus.stall      = w_haz_rs1 || w_haz_rs2;
    assign bus.writeReg   = r_write_reg;
    assign bus.writeData  = r_write_data;
    assign bus.RegWrite   = r_reg_write;
    assign bus.pending    = r_pending;
endmodule

// File: tb/tb_ctrl_escritura_banco.sv
// Directed and randomized bench for ctrl_escritura_banco: a behavioural model
// predicts grants, stalls and pending; a monitor pops expected writes.
module tb_ctrl_escritura_banco;
    logic clk;
    logic rst;

    ctrl_escritura_banco_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    ctrl_escritura_banco #(.DATA_W(32), .ADDR_W(5)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_q[$];
    int          n_total = 0;
    int          n_pass  = 0;

    // Behavioural model state.
    bit          m_known = 1'b0;
    bit          m_pend[32];
    int          m_last;          // requester granted most recently
    bit          m_out_we;
    logic [4:0]  m_out_reg;

    // Register file stand-in, written from the DUT write port.
    logic [31:0] rf[32];
    always @(posedge clk) if (bus.RegWrite === 1'b1) rf[bus.writeReg] <= bus.writeData;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] model_pending();
        logic [31:0] v = '0;
        for (int i = 0; i < 32; i++) v[i] = m_pend[i];
        return v;
    endfunction

    function automatic bit model_hazard(input logic [4:0] r);
        if (r == 0) return 1'b0;
        return m_pend[r] || (m_out_we && m_out_reg == r);
    endfunction

    // Monitor: every write presented by the DUT must match the next expected one.
    initial begin
        wr_t w;
        forever begin
            @(posedge clk);
            #1;
            if (bus.RegWrite === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("spurious_write", 1, 0);
                end else begin
                    w = exp_q.pop_front();
                    check("write_reg",  bus.writeReg,  w.r);
                    check("write_data", bus.writeData, w.d);
                end
            end
        end
    end

    // One clock cycle: drive at the falling edge, check, then advance the model.
    task automatic step(input bit rs, input bit v0, input logic [4:0] r0, input logic [31:0] d0,
                        input bit v1, input logic [4:0] r1, input logic [31:0] d1,
                        input bit rv, input logic [4:0] rr, input logic [4:0] s1, input logic [4:0] s2,
                        output bit a0, output bit a1);
        bit e0, e1;
        @(negedge clk);
        if (m_known) begin
            check("pending",  bus.pending,  model_pending());
            check("regwrite", bus.RegWrite, m_out_we);
        end
        rst = rs;
        bus.req0_valid = v0; bus.req0_reg = r0; bus.req0_data = d0;
        bus.req1_valid = v1; bus.req1_reg = r1; bus.req1_data = d1;
        bus.rsv_valid = rv;  bus.rsv_reg = rr;
        bus.rs1 = s1;        bus.rs2 = s2;
        #1;
        if (rs)            begin e0 = 0;            e1 = 0;       end
        else if (v0 && v1) begin e0 = (m_last == 1); e1 = !e0;    end
        else               begin e0 = v0;           e1 = v1;      end
        check("req0_ready", bus.req0_ready, e0);
        check("req1_ready", bus.req1_ready, e1);
        if (m_known) check("stall", bus.stall, model_hazard(s1) || model_hazard(s2));
        a0 = e0;
        a1 = e1;
        if (rs) begin
            foreach (m_pend[i]) m_pend[i] = 0;
            m_last   = 1;
            m_out_we = 0;
            m_known  = 1;
        end else begin
            logic [4:0] ar = e1 ? r1 : r0;
            m_out_we = 0;
            if ((e0 || e1) && ar != 0) begin
                wr_t w;
                w.r = ar;
                w.d = e1 ? d1 : d0;
                exp_q.push_back(w);
                m_last    = e1 ? 1 : 0;
                m_out_we  = 1;
                m_out_reg = ar;
                m_pend[ar] = 0;
            end
            if (rv && rr != 0) m_pend[rr] = 1;
        end
    endtask

    task automatic idle(input logic [4:0] s1);
        bit a0, a1;
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, s1, 0, a0, a1);
    endtask

    initial begin
        bit a0, a1;
        bit         v[2];
        logic [4:0]  r[2];
        logic [31:0] d[2];

        rst = 1'b1;
        // Reset held two cycles with both requesters valid.
        step(1, 1, 3, 32'h11, 1, 5, 32'h22, 0, 0, 0, 0, a0, a1);
        step(1, 1, 3, 32'h11, 1, 5, 32'h22, 0, 0, 0, 0, a0, a1);
        @(negedge clk);
        check("reset_writeReg",  bus.writeReg,  0);
        check("reset_writeData", bus.writeData, 0);
        check("reset_pending",   bus.pending,   0);
        // Contention 3 vs 5: each held until accepted, order 0,1,0,1.
        step(0, 1, 3, 32'h11, 1, 5, 32'h22, 0, 0, 0, 0, a0, a1);
        check("first_grant_req0", a0, 1);
        step(0, 0, 0, 0,      1, 5, 32'h22, 0, 0, 0, 0, a0, a1);
        step(0, 1, 3, 32'h33, 1, 5, 32'h44, 0, 0, 0, 0, a0, a1);
        step(0, 0, 0, 0,      1, 5, 32'h44, 0, 0, 0, 0, a0, a1);
        // Single request, then read back register 13.
        step(0, 0, 0, 0, 1, 13, 32'h0000A234, 0, 0, 0, 0, a0, a1);
        idle(0); idle(0);
        check("rf13_readback", rf[13], 32'h0000A234);
        // x0 write from req0 after req1 was last: contention still goes to req0.
        step(0, 1, 0, 32'h000000A1, 0, 0, 0, 0, 0, 0, 0, a0, a1);
        idle(0);
        step(0, 1, 3, 32'h55, 1, 5, 32'h66, 0, 0, 0, 0, a0, a1);
        check("x0_keeps_priority", a0, 1);
        step(0, 0, 0, 0, 1, 5, 32'h66, 0, 0, 0, 0, a0, a1);
        // Scoreboard: reserve 7, stall on rs1=7, clear by req1 write.
        step(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, a0, a1);
        idle(7);
        step(0, 0, 0, 0, 1, 7, 32'h77, 0, 0, 7, 0, a0, a1);
        idle(7);
        idle(7);
        // Reserve and clear of reg 7 in the same cycle.
        step(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, a0, a1);
        step(0, 0, 0, 0, 1, 7, 32'h78, 1, 7, 0, 0, a0, a1);
        idle(7);
        check("rsv_beats_clear", bus.pending[7], 1);
        // Reset in the cycle req0 presents reg 9 with pending[9] set.
        step(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, a0, a1);
        step(1, 1, 9, 32'h99, 0, 0, 0, 0, 0, 9, 0, a0, a1);
        idle(0);
        check("midreset_pending", bus.pending, 0);

        // Randomized traffic honouring the hold-until-ready rule.
        v[0] = 0; v[1] = 0;
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (!v[k] && $urandom_range(99) < 60) begin
                    v[k] = 1;
                    r[k] = 5'($urandom_range(7));
                    d[k] = $urandom;
                end
            end
            step(($urandom_range(99) == 0), v[0], r[0], d[0], v[1], r[1], d[1],
                 ($urandom_range(99) < 30), 5'($urandom_range(7)),
                 5'($urandom_range(7)), 5'($urandom_range(7)), a0, a1);
            if (a0) v[0] = 0;
            if (a1) v[1] = 0;
        end
        idle(0); idle(0); idle(0);
        check("all_writes_seen", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
